// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two client sequencers and the shared ALU arbiter.
// The master modport is the client side; the slave modport is the arbiter side.
interface alu_share_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic [2:0] req0_op;

   logic       req1_valid;
   logic       req1_ready;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic [2:0] req1_op;

   logic       rsp0_valid;
   logic       rsp0_ready;
   logic [8:0] rsp0_result;
   logic       rsp0_zero;
   logic       rsp0_ctrl;

   logic       rsp1_valid;
   logic       rsp1_ready;
   logic [8:0] rsp1_result;
   logic       rsp1_zero;
   logic       rsp1_ctrl;

   logic       busy;
   logic       last_grant;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_ctrl,
      output rsp0_ready,
      input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_ctrl,
      output rsp1_ready,
      input  busy, last_grant
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output rsp0_valid, rsp0_result, rsp0_zero, rsp0_ctrl,
      input  rsp0_ready,
      output rsp1_valid, rsp1_result, rsp1_zero, rsp1_ctrl,
      input  rsp1_ready,
      output busy, last_grant
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one 8-bit ALU: accept in IDLE, compute in EXEC,
// hold the registered result in RESP until the granted port takes it.
module alu_share_arbiter #(
   parameter bit PRIORITY_MODE = 1'b0
) (
   input logic                clk,
   input logic                reset,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_GT  = 3'b010;
   localparam logic [2:0] OP_EQ  = 3'b011;
   localparam logic [2:0] OP_LT  = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [2:0] op_q, op_d;
   logic       grant_q, grant_d;
   logic [8:0] result_q, result_d;
   logic       zero_q, zero_d;
   logic       ctrl_q, ctrl_d;
   logic       lastGrant_q, lastGrant_d;

   logic       winner;
   logic       accept;
   logic       rspTaken;
   logic [8:0] aluResult;
   logic       aluZero;
   logic       aluCtrl;

   // Winner is only meaningful when at least one port is valid; ties in
   // round-robin go to the port that did not complete last.
   always_comb begin
      winner = 1'b0;
      if (PRIORITY_MODE) begin
         winner = !bus.req0_valid && bus.req1_valid;
      end else if (bus.req0_valid && bus.req1_valid) begin
         winner = ~lastGrant_q;
      end else begin
         winner = bus.req1_valid;
      end
   end

   assign accept   = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid) && !reset;
   assign rspTaken = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

   always_comb begin
      aluResult = 9'h000;
      case (op_q)
         OP_ADD:  aluResult = {1'b0, a_q} + {1'b0, b_q};
         OP_SUB:  aluResult = {1'b0, a_q} - {1'b0, b_q};
         OP_GT:   aluResult = {8'h00, (a_q > b_q)};
         OP_EQ:   aluResult = {8'h00, (a_q == b_q)};
         OP_LT:   aluResult = {8'h00, (a_q < b_q)};
         OP_AND:  aluResult = {1'b0, a_q & b_q};
         OP_OR:   aluResult = {1'b0, a_q | b_q};
         OP_XOR:  aluResult = {1'b0, a_q ^ b_q};
         default: aluResult = 9'h000;
      endcase
      aluZero = (aluResult == 9'h000);
      aluCtrl = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? aluResult[8] : 1'b0;
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      grant_d     = grant_q;
      result_d    = result_q;
      zero_d      = zero_q;
      ctrl_d      = ctrl_q;
      lastGrant_d = lastGrant_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = winner ? bus.req1_a  : bus.req0_a;
               b_d     = winner ? bus.req1_b  : bus.req0_b;
               op_d    = winner ? bus.req1_op : bus.req0_op;
               grant_d = winner;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = aluResult;
            zero_d   = aluZero;
            ctrl_d   = aluCtrl;
            state_d  = RESP;
         end
         RESP: begin
            if (rspTaken) begin
               lastGrant_d = grant_q;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // lastGrant resets to 1 so port 0 wins the first simultaneous round-robin request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         op_q        <= 3'b000;
         grant_q     <= 1'b0;
         result_q    <= 9'h000;
         zero_q      <= 1'b0;
         ctrl_q      <= 1'b0;
         lastGrant_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         grant_q     <= grant_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         ctrl_q      <= ctrl_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   assign bus.req0_ready  = accept && !winner;
   assign bus.req1_ready  = accept && winner;

   assign bus.rsp0_valid  = (state_q == RESP) && !grant_q;
   assign bus.rsp1_valid  = (state_q == RESP) && grant_q;

   assign bus.rsp0_result = result_q;
   assign bus.rsp1_result = result_q;
   assign bus.rsp0_zero   = zero_q;
   assign bus.rsp1_zero   = zero_q;
   assign bus.rsp0_ctrl   = ctrl_q;
   assign bus.rsp1_ctrl   = ctrl_q;

   assign bus.busy        = (state_q != IDLE);
   assign bus.last_grant  = lastGrant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a vector table of single transactions
// plus hand-written round-robin, priority, backpressure and reset sequences.
module tb_alu_share_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   alu_share_arbiter_if busR ();
   alu_share_arbiter_if busP ();

   alu_share_arbiter #(.PRIORITY_MODE(1'b0)) dutR (
      .clk   (clk),
      .reset (reset),
      .bus   (busR.slave)
   );

   alu_share_arbiter #(.PRIORITY_MODE(1'b1)) dutP (
      .clk   (clk),
      .reset (reset),
      .bus   (busP.slave)
   );

   typedef struct {
      logic       port;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [8:0] expResult;
      logic       expZero;
      logic       expCtrl;
   } vec_t;

   vec_t vecs[12];
   int   checks   = 0;
   int   failures = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idleAll();
      busR.req0_valid = 1'b0; busR.req0_a = 8'h00; busR.req0_b = 8'h00; busR.req0_op = 3'b000;
      busR.req1_valid = 1'b0; busR.req1_a = 8'h00; busR.req1_b = 8'h00; busR.req1_op = 3'b000;
      busR.rsp0_ready = 1'b0; busR.rsp1_ready = 1'b0;
      busP.req0_valid = 1'b0; busP.req0_a = 8'h00; busP.req0_b = 8'h00; busP.req0_op = 3'b000;
      busP.req1_valid = 1'b0; busP.req1_a = 8'h00; busP.req1_b = 8'h00; busP.req1_op = 3'b000;
      busP.rsp0_ready = 1'b0; busP.rsp1_ready = 1'b0;
   endtask

   task automatic applyStimulus(input logic port, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      if (port) begin
         busR.req1_a = a; busR.req1_b = b; busR.req1_op = op; busR.req1_valid = 1'b1;
      end else begin
         busR.req0_a = a; busR.req0_b = b; busR.req0_op = op; busR.req0_valid = 1'b1;
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0]  = '{1'b0, 8'd200, 8'd100, 3'b000, 9'h12C, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 8'd5,   8'd7,   3'b001, 9'h1FE, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 8'h3C,  8'h3C,  3'b111, 9'h000, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 8'd7,   8'd5,   3'b001, 9'h002, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'd9,   8'd3,   3'b010, 9'h001, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'd4,   8'd4,   3'b011, 9'h001, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'd4,   8'd4,   3'b100, 9'h000, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 8'hF0,  8'h3C,  3'b101, 9'h030, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'hF0,  8'h0F,  3'b110, 9'h0FF, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 8'hFF,  8'h01,  3'b000, 9'h100, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 8'h00,  8'h00,  3'b000, 9'h000, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 8'h80,  8'h80,  3'b001, 9'h000, 1'b1, 1'b0};

      // Reset state, with both requests asserted to confirm ready is held low.
      idleAll();
      reset = 1'b1;
      busR.req0_valid = 1'b1;
      busR.req1_valid = 1'b1;
      repeat (2) @(negedge clk);
      settle();
      checkOutput("rst_req0_ready", busR.req0_ready, 1'b0);
      checkOutput("rst_req1_ready", busR.req1_ready, 1'b0);
      checkOutput("rst_rsp0_valid", busR.rsp0_valid, 1'b0);
      checkOutput("rst_rsp1_valid", busR.rsp1_valid, 1'b0);
      checkOutput("rst_busy", busR.busy, 1'b0);
      checkOutput("rst_last_grant", busR.last_grant, 1'b1);
      checkOutput("rst_result", busR.rsp0_result, 9'h000);
      checkOutput("rst_zero", busR.rsp0_zero, 1'b0);
      checkOutput("rst_ctrl", busR.rsp0_ctrl, 1'b0);
      idleAll();
      reset = 1'b0;

      // Table of single-port transactions.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op);
         settle();
         checkOutput("vec_ready_win", vecs[i].port ? busR.req1_ready : busR.req0_ready, 1'b1);
         checkOutput("vec_ready_lose", vecs[i].port ? busR.req0_ready : busR.req1_ready, 1'b0);
         tick();
         idleAll();
         settle();
         checkOutput("vec_exec_busy", busR.busy, 1'b1);
         checkOutput("vec_exec_rsp_valid", vecs[i].port ? busR.rsp1_valid : busR.rsp0_valid, 1'b0);
         tick();
         settle();
         checkOutput("vec_rsp_valid", vecs[i].port ? busR.rsp1_valid : busR.rsp0_valid, 1'b1);
         checkOutput("vec_other_valid", vecs[i].port ? busR.rsp0_valid : busR.rsp1_valid, 1'b0);
         checkOutput("vec_result", vecs[i].port ? busR.rsp1_result : busR.rsp0_result, vecs[i].expResult);
         checkOutput("vec_zero", vecs[i].port ? busR.rsp1_zero : busR.rsp0_zero, vecs[i].expZero);
         checkOutput("vec_ctrl", vecs[i].port ? busR.rsp1_ctrl : busR.rsp0_ctrl, vecs[i].expCtrl);
         if (vecs[i].port) busR.rsp1_ready = 1'b1; else busR.rsp0_ready = 1'b1;
         tick();
         idleAll();
         settle();
         checkOutput("vec_done_valid", vecs[i].port ? busR.rsp1_valid : busR.rsp0_valid, 1'b0);
         checkOutput("vec_done_busy", busR.busy, 1'b0);
         checkOutput("vec_last_grant", busR.last_grant, vecs[i].port);
      end

      // Round-robin with both ports valid and both consumers always ready.
      doReset();
      applyStimulus(1'b0, 8'd10, 8'd20, 3'b000);
      applyStimulus(1'b1, 8'hFF, 8'h0F, 3'b111);
      busR.rsp0_ready = 1'b1;
      busR.rsp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic g;
         g = logic'(i % 2);
         settle();
         checkOutput("rr_ready_win", g ? busR.req1_ready : busR.req0_ready, 1'b1);
         checkOutput("rr_ready_lose", g ? busR.req0_ready : busR.req1_ready, 1'b0);
         tick();
         settle();
         checkOutput("rr_exec_busy", busR.busy, 1'b1);
         checkOutput("rr_exec_valid", busR.rsp0_valid | busR.rsp1_valid, 1'b0);
         tick();
         settle();
         checkOutput("rr_rsp_valid", g ? busR.rsp1_valid : busR.rsp0_valid, 1'b1);
         checkOutput("rr_other_valid", g ? busR.rsp0_valid : busR.rsp1_valid, 1'b0);
         checkOutput("rr_result", busR.rsp0_result, g ? 9'h0F0 : 9'h01E);
         tick();
         settle();
         checkOutput("rr_last_grant", busR.last_grant, g);
      end
      idleAll();

      // Fixed priority: port 0 always wins while valid.
      doReset();
      busP.req0_a = 8'd1;  busP.req0_b = 8'd2;  busP.req0_op = 3'b000; busP.req0_valid = 1'b1;
      busP.req1_a = 8'hFF; busP.req1_b = 8'hFF; busP.req1_op = 3'b101; busP.req1_valid = 1'b1;
      busP.rsp0_ready = 1'b1;
      busP.rsp1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         checkOutput("pri_req0_ready", busP.req0_ready, 1'b1);
         checkOutput("pri_req1_ready", busP.req1_ready, 1'b0);
         tick();
         settle();
         checkOutput("pri_exec_req1_ready", busP.req1_ready, 1'b0);
         tick();
         settle();
         checkOutput("pri_rsp0_valid", busP.rsp0_valid, 1'b1);
         checkOutput("pri_rsp1_valid", busP.rsp1_valid, 1'b0);
         checkOutput("pri_result", busP.rsp0_result, 9'h003);
         tick();
         settle();
         checkOutput("pri_last_grant", busP.last_grant, 1'b0);
      end
      busP.req0_valid = 1'b0;
      settle();
      checkOutput("pri_drop_req1_ready", busP.req1_ready, 1'b1);
      checkOutput("pri_drop_req0_ready", busP.req0_ready, 1'b0);
      tick();
      busP.req1_valid = 1'b0;
      tick();
      settle();
      checkOutput("pri_port1_valid", busP.rsp1_valid, 1'b1);
      checkOutput("pri_port1_result", busP.rsp1_result, 9'h0FF);
      tick();
      settle();
      checkOutput("pri_port1_last_grant", busP.last_grant, 1'b1);
      idleAll();

      // Backpressure on port 0 while port 1 waits, with a stray rsp1_ready.
      doReset();
      applyStimulus(1'b0, 8'd200, 8'd100, 3'b000);
      settle();
      checkOutput("bp_req0_ready", busR.req0_ready, 1'b1);
      tick();
      busR.req0_valid = 1'b0;
      applyStimulus(1'b1, 8'd5, 8'd7, 3'b001);
      busR.rsp1_ready = 1'b1;
      settle();
      checkOutput("bp_exec_req1_ready", busR.req1_ready, 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
         settle();
         checkOutput("bp_rsp0_valid", busR.rsp0_valid, 1'b1);
         checkOutput("bp_rsp1_valid", busR.rsp1_valid, 1'b0);
         checkOutput("bp_result", busR.rsp0_result, 9'h12C);
         checkOutput("bp_ctrl", busR.rsp0_ctrl, 1'b1);
         checkOutput("bp_busy", busR.busy, 1'b1);
         checkOutput("bp_req1_ready", busR.req1_ready, 1'b0);
         tick();
      end
      busR.rsp0_ready = 1'b1;
      tick();
      busR.rsp0_ready = 1'b0;
      settle();
      checkOutput("bp_release_valid", busR.rsp0_valid, 1'b0);
      checkOutput("bp_release_last_grant", busR.last_grant, 1'b0);
      checkOutput("bp_release_req1_ready", busR.req1_ready, 1'b1);
      tick();
      busR.req1_valid = 1'b0;
      tick();
      settle();
      checkOutput("bp_port1_valid", busR.rsp1_valid, 1'b1);
      checkOutput("bp_port1_result", busR.rsp1_result, 9'h1FE);
      tick();
      settle();
      checkOutput("bp_port1_last_grant", busR.last_grant, 1'b1);
      checkOutput("bp_port1_busy", busR.busy, 1'b0);
      idleAll();

      // Reset during EXEC discards the operation.
      applyStimulus(1'b0, 8'd9, 8'd3, 3'b010);
      tick();
      reset = 1'b1;
      tick();
      settle();
      checkOutput("rexec_rsp0_valid", busR.rsp0_valid, 1'b0);
      checkOutput("rexec_rsp1_valid", busR.rsp1_valid, 1'b0);
      checkOutput("rexec_busy", busR.busy, 1'b0);
      checkOutput("rexec_result", busR.rsp0_result, 9'h000);
      checkOutput("rexec_last_grant", busR.last_grant, 1'b1);
      checkOutput("rexec_req0_ready", busR.req0_ready, 1'b0);
      reset = 1'b0;
      idleAll();

      // Reset during RESP drops the pending response.
      applyStimulus(1'b0, 8'h3C, 8'h3C, 3'b111);
      tick();
      idleAll();
      tick();
      settle();
      checkOutput("rresp_pre_valid", busR.rsp0_valid, 1'b1);
      checkOutput("rresp_pre_zero", busR.rsp0_zero, 1'b1);
      reset = 1'b1;
      tick();
      settle();
      checkOutput("rresp_rsp0_valid", busR.rsp0_valid, 1'b0);
      checkOutput("rresp_zero", busR.rsp0_zero, 1'b0);
      checkOutput("rresp_busy", busR.busy, 1'b0);
      checkOutput("rresp_last_grant", busR.last_grant, 1'b1);
      reset = 1'b0;
      applyStimulus(1'b0, 8'd1, 8'd1, 3'b000);
      applyStimulus(1'b1, 8'd1, 8'd1, 3'b000);
      settle();
      checkOutput("rresp_first_req0_ready", busR.req0_ready, 1'b1);
      checkOutput("rresp_first_req1_ready", busR.req1_ready, 1'b0);
      idleAll();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares one 8-bit ALU between two requesters using valid/ready handshakes.
- Arbitrates, latches the winner's operands and opcode, runs the combinational ALU for one cycle, and holds the registered result on the winner's response channel until it is taken.
- Sits between two client sequencers and the single shared ALU instance; the ALU is instantiated inside this block.

## Interface
- PRIORITY_MODE, default 0: 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  port request valid
- req0_ready / req1_ready  output  1  port request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  input  8 each  unsigned operands
- req0_op / req1_op  input  3  ALU opcode: 000 add, 001 sub, 010 A>B, 011 A==B, 100 A<B, 101 and, 110 or, 111 xor
- rsp0_valid / rsp1_valid  output  1  response valid for that port
- rsp0_ready / rsp1_ready  input  1  port consumes response
- rsp0_result / rsp1_result  output  9  ALU result
- rsp0_zero / rsp1_zero  output  1  result == 0
- rsp0_ctrl / rsp1_ctrl  output  1  result[8] for add/sub; 0 for all other ops
- busy  output  1  high in EXEC or RESP
- last_grant  output  1  port index of the most recently completed operation

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - Select a winner: PRIORITY_MODE=1 → port 0 if valid, else port 1. PRIORITY_MODE=0 → if both valid, the port != last_grant; otherwise the single valid port.
  - reqN_ready = 1 only for the winner (combinational from valid and state); 0 for the loser and in every other state.
  - On valid & ready: latch a, b, op and the grant index; go to EXEC.
- EXEC: the latched operands drive the ALU; its result, zero and ctrl are registered into the response registers at the end of the cycle; go to RESP.
- RESP
  - rspN_valid = 1 for the granted port only; the other port's rsp_valid stays 0.
  - The response payload is stable while valid.
  - On rspN_ready: drop valid, set last_grant = granted port, go to IDLE.
  - Requests arriving in EXEC or RESP are not accepted. The requester must hold valid and payload until ready is seen.
- Arithmetic is 9-bit unsigned.
  - add: A+B with carry in bit 8.
  - sub: A−B modulo 512, so bit 8 = 1 when A<B (borrow).
  - Compare ops return 0 or 1 in bit 0.
  - Logic ops zero-extend to 9 bits.
- rsp_result/zero/ctrl on both ports share one register set. Only the granted port's valid qualifies them.

## Timing
- Accept in cycle N (IDLE, valid&ready) → EXEC in N+1 → rsp_valid high from N+2.
- Minimum occupancy is 3 cycles per operation; the next accept is no earlier than the cycle after rsp handshake.
- rsp_ready already high when rsp_valid rises → handshake in N+2, IDLE in N+3.
- Back-to-back alternating requests therefore complete every 3 cycles.
- Reset (any state, including mid-EXEC or mid-RESP) takes effect at the next edge and discards any in-flight operation without a response:
  - state = IDLE
  - rsp0_valid = rsp1_valid = 0
  - result registers = 9'h000, zero = 0, ctrl = 0
  - busy = 0
  - last_grant = 1, so port 0 wins the first simultaneous round-robin request
  - req ready = 0 while reset is high
- Simultaneous request from one port and response-ready from the other: no effect. Only the granted port's rsp_ready is observed.
- rsp_ready asserted with rsp_valid low is ignored.

## Test plan
- Port 0 only, add A=200 B=100:
  - ready in cycle 0, rsp0_valid in cycle 2
  - result=9'h12C, ctrl=1, zero=0
  - rsp1_valid stays 0
- Port 1 only, sub A=5 B=7 → result=9'h1FE, ctrl=1, zero=0. Then xor A=8'h3C B=8'h3C → result=0, zero=1, ctrl=0.
- Both ports valid continuously after reset, round-robin:
  - grants alternate 0,1,0,1
  - each response appears 2 cycles after its accept
  - last_grant toggles after each handshake
- PRIORITY_MODE=1, both valid continuously → port 0 is served every time and port 1 never gets ready; drop req0_valid → port 1 served next.
- Backpressure: hold rsp0_ready low 5 cycles in RESP → rsp0_valid and payload stable, busy=1, req1_ready stays 0 despite req1_valid; release → IDLE, then port 1 accepted.
- Reset asserted during EXEC, then during RESP → next cycle all outputs are at reset values, no response is emitted, and the first post-reset simultaneous request grants port 0.
